alu_unit: RTL and testbench



---
 rtl/alu_unit_if.sv | 29 ++
 rtl/alu_unit.sv | 102 ++++++++++
 tb/tb_alu_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// rtl/alu_unit_if.sv - operand/result bundle between the EX-stage datapath and alu_unit
//
// Signals:
//   a, b     operands (16 bit)        master -> slave
//   alu_op   operation select (3 bit) master -> slave
//   flag_en  flag register load       master -> slave
//   result   combinational result     slave  -> master
//   zero     result == 0              slave  -> master
//   flags    registered {N, Z, C, V}  slave  -> master

interface alu_unit_if;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  alu_op;
    logic        flag_en;
    logic [15:0] result;
    logic        zero;
    logic [3:0]  flags;

    modport master (
        output a, b, alu_op, flag_en,
        input  result, zero, flags
    );

    modport slave (
        input  a, b, alu_op, flag_en,
        output result, zero, flags
    );
endinterface

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - 16-bit EX-stage ALU with registered N/Z/C/V flag register
//
// Ports:
//   clk    in  clock, used only by the flag register
//   reset  in  asynchronous active-high reset, clears flags
//   bus    alu_unit_if.slave: a, b, alu_op, flag_en in; result, zero, flags out
//
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
// Build option: define ALU_SHIFT_EN to compile in the shifter. Without it,
// opcodes 110/111 pass operand a through with C=0, V=0.

module alu_unit (
    input  logic       clk,
    input  logic       reset,
    alu_unit_if.slave  bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [16:0] sum_ext;
    logic [16:0] diff_ext;
    logic [15:0] res;
    logic        carry;
    logic        ovf;
    logic        res_zero;
    logic [3:0]  flags_q;

    // The 17th bit of the zero-extended sum is the carry out; for the
    // difference it wraps to 1 exactly when a < b unsigned, i.e. the borrow.
    assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};

`ifdef ALU_SHIFT_EN
    logic [3:0]  sh;
    logic [16:0] sll_ext;
    logic [16:0] srl_ext;

    // Widening by one bit catches the last bit shifted out: bit 16 of the
    // left shift is a[16-sh], bit 0 of the right shift is a[sh-1]. Both are
    // naturally 0 when sh == 0.
    assign sh      = bus.b[3:0];
    assign sll_ext = {1'b0, bus.a} << sh;
    assign srl_ext = {bus.a, 1'b0} >> sh;
`endif

    always_comb begin
        res   = 16'h0000;
        carry = 1'b0;
        ovf   = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                res   = sum_ext[15:0];
                carry = sum_ext[16];
                ovf   = (bus.a[15] == bus.b[15]) && (sum_ext[15] != bus.a[15]);
            end
            OP_SUB: begin
                res   = diff_ext[15:0];
                carry = diff_ext[16];
                ovf   = (bus.a[15] != bus.b[15]) && (diff_ext[15] != bus.a[15]);
            end
            OP_AND: res = bus.a & bus.b;
            OP_OR:  res = bus.a | bus.b;
            OP_XOR: res = bus.a ^ bus.b;
            OP_SLT: res = ($signed(bus.a) < $signed(bus.b)) ? 16'h0001 : 16'h0000;
`ifdef ALU_SHIFT_EN
            OP_SLL: begin
                res   = sll_ext[15:0];
                carry = sll_ext[16];
            end
            OP_SRL: begin
                res   = srl_ext[16:1];
                carry = srl_ext[0];
            end
`else
            OP_SLL: res = bus.a;
            OP_SRL: res = bus.a;
`endif
            default: res = 16'h0000;
        endcase
    end

    assign res_zero   = (res == 16'h0000);
    assign bus.result = res;
    assign bus.zero   = res_zero;
    assign bus.flags  = flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (bus.flag_en) begin
            flags_q <= {res[15], res_zero, carry, ovf};
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - scoreboard testbench for alu_unit with directed vectors

module tb_alu_unit;

    logic clk;
    logic reset;

    alu_unit_if bus ();

    alu_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        en;
        logic [15:0] res;
        logic        zero;
        logic [3:0]  flags;   // flags visible during this cycle (before its edge)
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        zero;
        logic [3:0]  flags;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic vld;
    int   vidx;
    int   checks;
    int   failures;

    task automatic add(input logic rst, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic en, input logic [15:0] res,
                       input logic zero, input logic [3:0] flags);
        vec_t v;
        v.rst = rst; v.a = a; v.b = b; v.op = op; v.en = en;
        v.res = res; v.zero = zero; v.flags = flags;
        vecs.push_back(v);
    endtask

    // Monitor: result/zero are combinational, so each driven cycle is an
    // output beat; sample at the falling edge, away from the flag edge.
    always @(negedge clk) begin
        if (vld) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.result !== e.res) begin
                    failures++;
                    $display("FAIL result[%0d] actual=%h required=%h", e.idx, bus.result, e.res);
                end
                checks++;
                if (bus.zero !== e.zero) begin
                    failures++;
                    $display("FAIL zero[%0d] actual=%b required=%b", e.idx, bus.zero, e.zero);
                end
                checks++;
                if (bus.flags !== e.flags) begin
                    failures++;
                    $display("FAIL flags[%0d] actual=%b required=%b", e.idx, bus.flags, e.flags);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        vld      = 1'b0;
        vidx     = 0;
        reset    = 1'b1;
        bus.a = '0; bus.b = '0; bus.alu_op = '0; bus.flag_en = 1'b0;

        //   rst  a        b        op      en   res      z     flags
        add(1'b1, 16'h0000, 16'h0000, 3'b000, 1'b1, 16'h0000, 1'b1, 4'b0000); // reset, en ignored
        add(1'b0, 16'h7FFF, 16'h0001, 3'b000, 1'b1, 16'h8000, 1'b0, 4'b0000); // ADD overflow
        add(1'b0, 16'h1234, 16'h1234, 3'b001, 1'b1, 16'h0000, 1'b1, 4'b1001); // SUB equal
        add(1'b0, 16'h0001, 16'h0002, 3'b001, 1'b1, 16'hFFFF, 1'b0, 4'b0100); // SUB borrow
        add(1'b0, 16'hF0F0, 16'h0FF0, 3'b010, 1'b0, 16'h00F0, 1'b0, 4'b1010); // AND, hold
        add(1'b0, 16'hF0F0, 16'h0FF0, 3'b011, 1'b0, 16'hFFF0, 1'b0, 4'b1010); // OR, hold
        add(1'b0, 16'hF0F0, 16'h0FF0, 3'b100, 1'b1, 16'hFF00, 1'b0, 4'b1010); // XOR
        add(1'b0, 16'hFFFD, 16'h0002, 3'b101, 1'b1, 16'h0001, 1'b0, 4'b1000); // SLT -3<2
        add(1'b0, 16'h0002, 16'hFFFD, 3'b101, 1'b1, 16'h0000, 1'b1, 4'b0000); // SLT swapped
`ifdef ALU_SHIFT_EN
        add(1'b0, 16'h8001, 16'hFFF1, 3'b110, 1'b1, 16'h0002, 1'b0, 4'b0100); // SLL sh=1
        add(1'b0, 16'h8001, 16'hFFF1, 3'b111, 1'b1, 16'h4000, 1'b0, 4'b0010); // SRL sh=1
        add(1'b0, 16'h1234, 16'h0010, 3'b110, 1'b1, 16'h1234, 1'b0, 4'b0010); // sh=0
        add(1'b0, 16'h4000, 16'h0001, 3'b110, 1'b1, 16'h8000, 1'b0, 4'b0000); // SLL into sign
        add(1'b0, 16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 1'b1, 4'b1000); // hold
        add(1'b0, 16'hFFFF, 16'h0001, 3'b000, 1'b1, 16'h0000, 1'b1, 4'b1000); // load
`else
        add(1'b0, 16'h8001, 16'hFFF1, 3'b110, 1'b1, 16'h8001, 1'b0, 4'b0100); // pass-through
        add(1'b0, 16'h8001, 16'hFFF1, 3'b111, 1'b1, 16'h8001, 1'b0, 4'b1000); // pass-through
        add(1'b0, 16'h1234, 16'h0010, 3'b110, 1'b1, 16'h1234, 1'b0, 4'b1000);
        add(1'b0, 16'h4000, 16'h0001, 3'b110, 1'b1, 16'h4000, 1'b0, 4'b0000);
        add(1'b0, 16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 1'b1, 4'b0000); // hold
        add(1'b0, 16'hFFFF, 16'h0001, 3'b000, 1'b1, 16'h0000, 1'b1, 4'b0000); // load
`endif
        add(1'b1, 16'hFFFF, 16'h0001, 3'b000, 1'b1, 16'h0000, 1'b1, 4'b0000); // async reset mid-cycle
        add(1'b0, 16'h8000, 16'h8000, 3'b000, 1'b1, 16'h0000, 1'b1, 4'b0000); // first edge after reset
        add(1'b0, 16'h0000, 16'h0000, 3'b010, 1'b0, 16'h0000, 1'b1, 4'b0111);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clk);
            #1;
            reset       = vecs[i].rst;
            bus.a       = vecs[i].a;
            bus.b       = vecs[i].b;
            bus.alu_op  = vecs[i].op;
            bus.flag_en = vecs[i].en;
            e.idx   = i;
            e.res   = vecs[i].res;
            e.zero  = vecs[i].zero;
            e.flags = vecs[i].flags;
            sb.push_back(e);
            vld = 1'b1;
        end
        @(posedge clk);
        #1;
        vld = 1'b0;
        bus.flag_en = 1'b0;
        @(negedge clk);
        #1;

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
